// File: rtl/concat_mult_add_grad.sv
// Backward pass of the LSTM gate pre-activation unit: dX, dh outputs plus dW0/dW1/db accumulators.
// A single shared signed multiplier is time-multiplexed across four product steps by the FSM.
module concat_mult_add_grad #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FRACT_WIDTH = 8,
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] delta,
    input  logic [DATA_WIDTH-1:0] X,
    input  logic [DATA_WIDTH-1:0] h_in,
    input  logic [DATA_WIDTH-1:0] W0,
    input  logic [DATA_WIDTH-1:0] W1,
    input  logic                  acc_clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] dx_out,
    output logic [DATA_WIDTH-1:0] dh_out,
    output logic [ACC_WIDTH-1:0]  dw0_acc,
    output logic [ACC_WIDTH-1:0]  dw1_acc,
    output logic [ACC_WIDTH-1:0]  db_acc,
    output logic [CNT_WIDTH-1:0]  acc_count
);

    localparam int unsigned PW    = 2 * DATA_WIDTH;
    localparam int unsigned SUM_W = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;

    localparam logic signed [SUM_W-1:0] ACC_MAX =
        {{(SUM_W - ACC_WIDTH + 1){1'b0}}, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN =
        {{(SUM_W - ACC_WIDTH + 1){1'b1}}, {(ACC_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StMulDx,
        StMulDh,
        StMulDw0,
        StMulDw1,
        StOut
    } state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_delta;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_h;
    logic [DATA_WIDTH-1:0] r_w0;
    logic [DATA_WIDTH-1:0] r_w1;
    logic [DATA_WIDTH-1:0] r_dx;
    logic [DATA_WIDTH-1:0] r_dh;
    logic [ACC_WIDTH-1:0]  r_dw0_acc;
    logic [ACC_WIDTH-1:0]  r_dw1_acc;
    logic [ACC_WIDTH-1:0]  r_db_acc;
    logic [CNT_WIDTH-1:0]  r_acc_count;

    logic [DATA_WIDTH-1:0] w_mul_b;
    logic signed [PW-1:0]  w_prod;
    logic signed [PW-1:0]  w_prod_sh;
    logic [SUM_W-1:0]      w_term;
    logic [SUM_W-1:0]      w_delta_ext;
    logic [ACC_WIDTH-1:0]  w_dw0_base;
    logic [ACC_WIDTH-1:0]  w_dw1_base;
    logic [ACC_WIDTH-1:0]  w_db_base;
    logic [CNT_WIDTH-1:0]  w_cnt_next;

    function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [SUM_W-1:0] b);
        logic signed [SUM_W-1:0] s;
        s = $signed({{(SUM_W - ACC_WIDTH){a[ACC_WIDTH-1]}}, a}) + $signed(b);
        if (s > ACC_MAX) begin
            s = ACC_MAX;
        end else if (s < ACC_MIN) begin
            s = ACC_MIN;
        end
        return s[ACC_WIDTH-1:0];
    endfunction

    always_comb begin
        w_mul_b = r_w0;
        case (r_state)
            StMulDh:  w_mul_b = r_w1;
            StMulDw0: w_mul_b = r_x;
            StMulDw1: w_mul_b = r_h;
            default:  w_mul_b = r_w0;
        endcase
    end

    assign w_prod      = $signed({{DATA_WIDTH{r_delta[DATA_WIDTH-1]}}, r_delta}) *
                         $signed({{DATA_WIDTH{w_mul_b[DATA_WIDTH-1]}}, w_mul_b});
    assign w_prod_sh   = w_prod >>> FRACT_WIDTH;
    assign w_term      = {{(SUM_W - PW){w_prod_sh[PW-1]}}, w_prod_sh};
    assign w_delta_ext = {{(SUM_W - DATA_WIDTH){delta[DATA_WIDTH-1]}}, delta};

    // A coincident clear makes this cycle's update start from zero.
    assign w_dw0_base = acc_clear ? '0 : r_dw0_acc;
    assign w_dw1_base = acc_clear ? '0 : r_dw1_acc;
    assign w_db_base  = acc_clear ? '0 : r_db_acc;
    assign w_cnt_next = acc_clear ? {{(CNT_WIDTH - 1){1'b0}}, 1'b1} :
                        (&r_acc_count) ? r_acc_count :
                        r_acc_count + {{(CNT_WIDTH - 1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_delta     <= '0;
            r_x         <= '0;
            r_h         <= '0;
            r_w0        <= '0;
            r_w1        <= '0;
            r_dx        <= '0;
            r_dh        <= '0;
            r_dw0_acc   <= '0;
            r_dw1_acc   <= '0;
            r_db_acc    <= '0;
            r_acc_count <= '0;
        end else begin
            if (acc_clear) begin
                r_dw0_acc   <= '0;
                r_dw1_acc   <= '0;
                r_db_acc    <= '0;
                r_acc_count <= '0;
            end
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_delta     <= delta;
                        r_x         <= X;
                        r_h         <= h_in;
                        r_w0        <= W0;
                        r_w1        <= W1;
                        r_db_acc    <= sat_add(w_db_base, w_delta_ext);
                        r_acc_count <= w_cnt_next;
                        r_in_ready  <= 1'b0;
                        r_state     <= StMulDx;
                    end
                end
                StMulDx: begin
                    r_dx    <= w_prod_sh[DATA_WIDTH-1:0];
                    r_state <= StMulDh;
                end
                StMulDh: begin
                    r_dh    <= w_prod_sh[DATA_WIDTH-1:0];
                    r_state <= StMulDw0;
                end
                StMulDw0: begin
                    r_dw0_acc <= sat_add(w_dw0_base, w_term);
                    r_state   <= StMulDw1;
                end
                StMulDw1: begin
                    r_dw1_acc   <= sat_add(w_dw1_base, w_term);
                    r_out_valid <= 1'b1;
                    r_state     <= StOut;
                end
                StOut: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign dx_out    = r_dx;
    assign dh_out    = r_dh;
    assign dw0_acc   = r_dw0_acc;
    assign dw1_acc   = r_dw1_acc;
    assign db_acc    = r_db_acc;
    assign acc_count = r_acc_count;

endmodule

// File: tb/tb_concat_mult_add_grad.sv
// Directed bench for concat_mult_add_grad: vector table plus handshake, saturation and reset cases.
module tb_concat_mult_add_grad;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, acc_clear, out_valid, out_ready;
    logic [15:0] delta, X, h_in, W0, W1, dx_out, dh_out, acc_count;
    logic [31:0] dw0_acc, dw1_acc, db_acc;

    logic        s_in_valid, s_in_ready, s_out_valid;
    logic [15:0] s_delta, s_x, s_dx, s_dh, s_cnt;
    logic [23:0] s_dw0, s_dw1, s_db;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    concat_mult_add_grad dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .delta(delta), .X(X), .h_in(h_in), .W0(W0), .W1(W1), .acc_clear(acc_clear),
        .out_valid(out_valid), .out_ready(out_ready), .dx_out(dx_out), .dh_out(dh_out),
        .dw0_acc(dw0_acc), .dw1_acc(dw1_acc), .db_acc(db_acc), .acc_count(acc_count)
    );

    concat_mult_add_grad #(.ACC_WIDTH(24)) dut24 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .delta(s_delta), .X(s_x), .h_in(16'd0), .W0(16'd0), .W1(16'd0), .acc_clear(1'b0),
        .out_valid(s_out_valid), .out_ready(1'b1), .dx_out(s_dx), .dh_out(s_dh),
        .dw0_acc(s_dw0), .dw1_acc(s_dw1), .db_acc(s_db), .acc_count(s_cnt)
    );

    typedef struct {
        logic [15:0] d, w0, w1, x, h;
        logic [15:0] exp_dx, exp_dh;
        logic [31:0] exp_dw0, exp_dw1, exp_db;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from the accept edge (cycle 1 is right after it) until out_valid.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        delta = v.d; W0 = v.w0; W1 = v.w1; X = v.x; h_in = v.h;
        in_valid = 1'b1; acc_clear = 1'b1;
        tick();
        in_valid = 1'b0; acc_clear = 1'b0;
        delta = 16'h5a5a; W0 = 16'ha5a5; W1 = 16'h1234; X = 16'h7777; h_in = 16'h8001;
        check($sformatf("v%0d_busy_ready", idx), in_ready, 0);
        wait_out(lat);
        check($sformatf("v%0d_latency", idx), lat, 5);
        check($sformatf("v%0d_dx", idx), dx_out, v.exp_dx);
        check($sformatf("v%0d_dh", idx), dh_out, v.exp_dh);
        check($sformatf("v%0d_dw0", idx), dw0_acc, v.exp_dw0);
        check($sformatf("v%0d_dw1", idx), dw1_acc, v.exp_dw1);
        check($sformatf("v%0d_db", idx), db_acc, v.exp_db);
        check($sformatf("v%0d_cnt", idx), acc_count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check($sformatf("v%0d_ready_after", idx), in_ready, 1);
        check($sformatf("v%0d_valid_after", idx), out_valid, 0);
    endtask

    function automatic vec_t mkv(input logic [15:0] d, w0, w1, x, h, edx, edh,
                                 input logic [31:0] edw0, edw1, edb);
        vec_t v;
        v.d = d; v.w0 = w0; v.w1 = w1; v.x = x; v.h = h;
        v.exp_dx = edx; v.exp_dh = edh; v.exp_dw0 = edw0; v.exp_dw1 = edw1; v.exp_db = edb;
        return v;
    endfunction

    initial begin
        int lat, n, guard, bad;
        int stamp[3];
        logic [23:0] exp24[3];

        vecs[0] = mkv(16'd256, 16'd512, -16'sd256, 16'd128, 16'd64,
                      16'd512, 16'hff00, 32'd128, 32'd64, 32'd256);
        vecs[1] = mkv(16'd32767, 16'd32767, 16'd0, 16'd0, 16'd0,
                      16'hff00, 16'd0, 32'd0, 32'd0, 32'd32767);
        vecs[2] = mkv(-16'sd1, 16'd0, 16'd0, 16'd1, 16'd0,
                      16'd0, 16'd0, 32'hffffffff, 32'd0, 32'hffffffff);
        vecs[3] = mkv(-16'sd3, 16'd100, -16'sd100, 16'd7, -16'sd7,
                      16'hfffe, 16'd1, 32'hffffffff, 32'd0, 32'hfffffffd);
        vecs[4] = mkv(16'h8000, 16'h8000, 16'd32767, 16'h8000, 16'd32767,
                      16'h0000, 16'h0080, 32'd4194304, -32'sd4194176, -32'sd32768);
        vecs[5] = mkv(16'd1, 16'd255, -16'sd255, 16'd256, -16'sd257,
                      16'd0, 16'hffff, 32'd1, -32'sd2, 32'd1);
        exp24[0] = 24'd4194048; exp24[1] = 24'd8388096; exp24[2] = 24'd8388607;

        rst = 1'b1; in_valid = 1'b0; acc_clear = 1'b0; out_ready = 1'b0;
        delta = '0; X = '0; h_in = '0; W0 = '0; W1 = '0;
        s_in_valid = 1'b0; s_delta = '0; s_x = '0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_dx", dx_out, 0);
        check("rst_dw0", dw0_acc, 0);
        check("rst_db", db_acc, 0);
        check("rst_cnt", acc_count, 0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Accumulation: three back-to-back T1 samples with out_ready held high.
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        check("clear_idle_dw0", dw0_acc, 0);
        check("clear_idle_cnt", acc_count, 0);
        delta = 16'd256; W0 = 16'd512; W1 = -16'sd256; X = 16'd128; h_in = 16'd64;
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0; guard = 0;
        while (n < 3 && guard < 100) begin
            if (in_ready) begin
                stamp[n] = cyc;
                n++;
            end
            tick();
            guard++;
        end
        in_valid = 1'b0;
        check("acc_accepts", n, 3);
        check("acc_interval1", stamp[1] - stamp[0], 6);
        check("acc_interval2", stamp[2] - stamp[1], 6);
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        out_ready = 1'b0;
        check("acc_drain", in_ready, 1);
        check("acc_dw0", dw0_acc, 384);
        check("acc_dw1", dw1_acc, 192);
        check("acc_db", db_acc, 768);
        check("acc_cnt", acc_count, 3);

        // Backpressure: result held for 10 cycles; a pending in_valid waits for out_ready.
        in_valid = 1'b1; acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        delta = 16'd100; W0 = 16'd256; W1 = 16'd256; X = 16'd0; h_in = 16'd0;
        wait_out(lat);
        check("bp_latency", lat, 5);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || in_ready || dx_out !== 16'd512 || dh_out !== 16'hff00 ||
                acc_count !== 16'd1)
                bad++;
        end
        check("bp_hold", bad, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_ready", in_ready, 1);
        check("bp_release_cnt", acc_count, 1);
        tick();
        in_valid = 1'b0;
        check("bp_held_accept_ready", in_ready, 0);
        check("bp_held_accept_cnt", acc_count, 2);
        check("bp_held_accept_db", db_acc, 356);
        wait_out(lat);
        check("bp2_latency", lat, 5);
        check("bp2_dx", dx_out, 100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Saturation on the 24-bit accumulator instance.
        for (int k = 0; k < 3; k++) begin
            s_delta = 16'd32767; s_x = 16'd32767;
            guard = 0;
            while (!s_in_ready && guard < 20) begin
                tick();
                guard++;
            end
            s_in_valid = 1'b1;
            tick();
            s_in_valid = 1'b0;
            guard = 0;
            while (!s_out_valid && guard < 20) begin
                tick();
                guard++;
            end
            check($sformatf("sat_valid%0d", k), s_out_valid, 1);
            check($sformatf("sat_dw0_%0d", k), s_dw0, exp24[k]);
            tick();
        end
        check("sat_db", s_db, 24'd98301);
        check("sat_cnt", s_cnt, 3);

        // Asynchronous reset while in M_DH.
        delta = 16'd256; W0 = 16'd512; W1 = 16'd256; X = 16'd128; h_in = 16'd64;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_dx", dx_out, 0);
        check("arst_dw0", dw0_acc, 0);
        check("arst_db", db_acc, 0);
        check("arst_cnt", acc_count, 0);
        #3;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid || !in_ready) bad++;
        end
        check("arst_no_partial", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
